// File: rtl/trig_pkg.sv
// Shared types and constants for the trigger/capture sequencer.
//   state_e        : sequencer states, also exported on state_o for debug
//   Mode*          : capture mode encodings (3 behaves as normal)
//   Src* / Slope*  : trigger source channel and edge polarity encodings
package trig_pkg;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StPreFill = 3'd1,
      StArmed   = 3'd2,
      StPost    = 3'd3,
      StDone    = 3'd4
   } state_e;

   localparam logic [1:0] ModeAuto   = 2'd0;
   localparam logic [1:0] ModeNormal = 2'd1;
   localparam logic [1:0] ModeSingle = 2'd2;

   localparam logic SrcA         = 1'b0;
   localparam logic SrcB         = 1'b1;
   localparam logic SlopeRising  = 1'b0;
   localparam logic SlopeFalling = 1'b1;

   // States in which valid samples are written to the BRAM half.
   function automatic logic is_write_state(input state_e st);
      return (st == StPreFill) || (st == StArmed) || (st == StPost);
   endfunction

endpackage

// File: rtl/trig_capture_ctrl_detect.sv
// Edge trigger comparator with hysteresis.
//   clk, rst_n : clock, async active-low reset
//   clear      : hold the below/above flags cleared (sequencer not armed)
//   eval       : a valid sample is being evaluated this cycle
//   slope      : 0 rising, 1 falling
//   sample     : signed sample of the selected channel
//   level      : signed threshold
//   hyst       : unsigned hysteresis
//   fire       : combinational pulse, aligned with the sample that fired
module trig_detect
   import trig_pkg::*;
#(
   parameter int unsigned W = 14
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         eval,
   input  logic         slope,
   input  logic [W-1:0] sample,
   input  logic [W-1:0] level,
   input  logic [W-1:0] hyst,
   output logic         fire
);

   logic below_q, below_d;
   logic above_q, above_d;

   logic signed [W:0] s_x, lvl_x, lo_x, hi_x;

   assign s_x   = {sample[W-1], sample};
   assign lvl_x = {level[W-1], level};
   assign lo_x  = lvl_x - {1'b0, hyst};
   assign hi_x  = lvl_x + {1'b0, hyst};

   always_comb begin
      fire    = 1'b0;
      below_d = below_q;
      above_d = above_q;
      if (clear) begin
         below_d = 1'b0;
         above_d = 1'b0;
      end else if (eval) begin
         if (slope == SlopeRising) begin
            if (below_q && (s_x >= lvl_x)) begin
               fire    = 1'b1;
               below_d = 1'b0;
            end else if (s_x < lo_x) begin
               below_d = 1'b1;
            end
         end else begin
            if (above_q && (s_x <= lvl_x)) begin
               fire    = 1'b1;
               above_d = 1'b0;
            end else if (s_x > hi_x) begin
               above_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         below_q <= 1'b0;
         above_q <= 1'b0;
      end else begin
         below_q <= below_d;
         above_q <= above_d;
      end
   end

endmodule

// File: rtl/trig_capture_ctrl.sv
// Trigger/acquisition sequencer feeding one ping-pong BRAM write port.
// Captures a pre/post-trigger frame into one half and publishes it to the reader.
//   clk, rst_n        : ADC sample clock, async active-low reset
//   adc_pair          : {A, B} signed samples; sample_valid qualifies them
//   trig_src/slope    : trigger channel (0 A, 1 B) and edge (0 rising, 1 falling)
//   trig_level/hyst   : signed threshold, unsigned hysteresis
//   mode              : 0 auto, 1 normal, 2 single, 3 normal
//   pretrig           : samples kept before the trigger
//   arm               : single-shot arm pulse (honoured in IDLE only)
//   rd_release        : reader done with frame_half
//   wr_en/addr/data   : BRAM port A, one cycle after the sample
//   frame_valid/half  : published frame and the half holding it
//   trig_addr, forced : trigger position in that half, auto-forced flag
//   state_o           : current state
module trig_capture_ctrl
   import trig_pkg::*;
#(
   parameter int unsigned W       = 14,
   parameter int unsigned AW      = 10,
   parameter int unsigned AUTO_TO = 60000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [2*W-1:0]  adc_pair,
   input  logic            sample_valid,
   input  logic            trig_src,
   input  logic            trig_slope,
   input  logic [W-1:0]    trig_level,
   input  logic [W-1:0]    trig_hyst,
   input  logic [1:0]      mode,
   input  logic [AW-1:0]   pretrig,
   input  logic            arm,
   input  logic            rd_release,
   output logic            wr_en,
   output logic [AW:0]     wr_addr,
   output logic [2*W-1:0]  wr_data,
   output logic            frame_valid,
   output logic            frame_half,
   output logic [AW-1:0]   trig_addr,
   output logic            forced,
   output logic [2:0]      state_o
);

   localparam int unsigned ToW = $clog2(AUTO_TO + 1);

   state_e          state_q, state_d;
   logic            half_q, half_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic [ToW-1:0]  to_q, to_d;
   logic [AW-1:0]   trig_int_q, trig_int_d;
   logic            forced_int_q, forced_int_d;

   logic            fv_q, fv_d;
   logic            fhalf_q, fhalf_d;
   logic [AW-1:0]   taddr_q, taddr_d;
   logic            forced_q, forced_d;

   logic            wr_en_q;
   logic [AW:0]     wr_addr_q;
   logic [2*W-1:0]  wr_data_q;

   // Configuration held for the whole frame.
   logic            cfg_src_q, cfg_slope_q;
   logic [W-1:0]    cfg_level_q, cfg_hyst_q;
   logic [1:0]      cfg_mode_q;
   logic [AW-1:0]   cfg_pretrig_q;
   logic            cfg_load;

   logic            adv, start, eval, fire, force_trig;
   logic [W-1:0]    trig_sample;
   logic [AW-1:0]   cnt_inc;

   assign adv         = sample_valid && is_write_state(state_q);
   assign eval        = sample_valid && (state_q == StArmed);
   assign trig_sample = (cfg_src_q == SrcB) ? adc_pair[W-1:0] : adc_pair[2*W-1:W];
   assign cnt_inc     = cnt_q + 1'b1;
   // A genuine edge on the timeout sample wins, so forced stays 0 then.
   assign force_trig  = eval && (cfg_mode_q == ModeAuto) && !fire &&
                        (to_q == ToW'(AUTO_TO - 1));

   trig_detect #(
      .W (W)
   ) u_detect (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (state_q != StArmed),
      .eval   (eval),
      .slope  (cfg_slope_q),
      .sample (trig_sample),
      .level  (cfg_level_q),
      .hyst   (cfg_hyst_q),
      .fire   (fire)
   );

   always_comb begin
      state_d      = state_q;
      half_d       = half_q;
      ptr_d        = ptr_q;
      cnt_d        = cnt_q;
      to_d         = '0;
      trig_int_d   = trig_int_q;
      forced_int_d = forced_int_q;
      fv_d         = fv_q;
      fhalf_d      = fhalf_q;
      taddr_d      = taddr_q;
      forced_d     = forced_q;
      start        = 1'b0;
      cfg_load     = 1'b0;

      if (adv) begin
         ptr_d = ptr_q + 1'b1;
      end
      // Release is applied before any publish below, which may re-set it.
      if (rd_release) begin
         fv_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (mode != ModeSingle || arm) begin
               start = 1'b1;
            end
         end
         StPreFill: begin
            if (sample_valid) begin
               cnt_d = cnt_inc;
               if (cnt_inc == cfg_pretrig_q) begin
                  state_d = StArmed;
               end
            end
         end
         StArmed: begin
            to_d = to_q;
            if (sample_valid) begin
               if (fire || force_trig) begin
                  trig_int_d   = ptr_q;
                  forced_int_d = force_trig;
                  cnt_d        = ~cfg_pretrig_q;
                  // Full pretrig leaves no post samples: the frame ends here.
                  state_d      = (cfg_pretrig_q == '1) ? StDone : StPost;
               end else if (to_q != ToW'(AUTO_TO - 1)) begin
                  to_d = to_q + 1'b1;
               end
            end
         end
         StPost: begin
            if (sample_valid) begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == AW'(1)) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            if (!fv_q || rd_release) begin
               fv_d     = 1'b1;
               fhalf_d  = half_q;
               taddr_d  = trig_int_q;
               forced_d = forced_int_q;
               half_d   = ~half_q;
               if (cfg_mode_q == ModeSingle || mode == ModeSingle) begin
                  state_d = StIdle;
               end else begin
                  start = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // New capture: latch live configuration, pretrig 0 goes straight to ARMED.
      if (start) begin
         cfg_load = 1'b1;
         cnt_d    = '0;
         state_d  = (pretrig == '0) ? StArmed : StPreFill;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         half_q       <= 1'b0;
         ptr_q        <= '0;
         cnt_q        <= '0;
         to_q         <= '0;
         trig_int_q   <= '0;
         forced_int_q <= 1'b0;
         fv_q         <= 1'b0;
         fhalf_q      <= 1'b0;
         taddr_q      <= '0;
         forced_q     <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         half_q       <= half_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         to_q         <= to_d;
         trig_int_q   <= trig_int_d;
         forced_int_q <= forced_int_d;
         fv_q         <= fv_d;
         fhalf_q      <= fhalf_d;
         taddr_q      <= taddr_d;
         forced_q     <= forced_d;
         wr_en_q      <= adv;
         wr_addr_q    <= {half_q, ptr_q};
         wr_data_q    <= adc_pair;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_src_q     <= 1'b0;
         cfg_slope_q   <= 1'b0;
         cfg_level_q   <= '0;
         cfg_hyst_q    <= '0;
         cfg_mode_q    <= '0;
         cfg_pretrig_q <= '0;
      end else if (cfg_load) begin
         cfg_src_q     <= trig_src;
         cfg_slope_q   <= trig_slope;
         cfg_level_q   <= trig_level;
         cfg_hyst_q    <= trig_hyst;
         cfg_mode_q    <= mode;
         cfg_pretrig_q <= pretrig;
      end
   end

   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign frame_valid = fv_q;
   assign frame_half  = fhalf_q;
   assign trig_addr   = taddr_q;
   assign forced      = forced_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_trig_capture_ctrl.sv
// Self-checking bench for trig_capture_ctrl: directed steps, write scoreboard.
module tb_trig_capture_ctrl;
   import trig_pkg::*;

   localparam int W       = 14;
   localparam int AW      = 10;
   localparam int AUTO_TO = 1000;

   typedef logic [AW+2*W:0] sb_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [2*W-1:0]  adc_pair = '0;
   logic            sample_valid = 1'b0;
   logic            trig_src = 1'b0;
   logic            trig_slope = 1'b0;
   logic [W-1:0]    trig_level = '0;
   logic [W-1:0]    trig_hyst = '0;
   logic [1:0]      mode = '0;
   logic [AW-1:0]   pretrig = '0;
   logic            arm = 1'b0;
   logic            rd_release = 1'b0;
   logic            wr_en;
   logic [AW:0]     wr_addr;
   logic [2*W-1:0]  wr_data;
   logic            frame_valid;
   logic            frame_half;
   logic [AW-1:0]   trig_addr;
   logic            forced;
   logic [2:0]      state_o;

   int              n_assert = 0;
   int              n_fail = 0;
   sb_t             sb[$];
   logic [AW-1:0]   exp_ptr = '0;
   logic            exp_half = 1'b0;

   always #5 clk = ~clk;

   trig_capture_ctrl #(
      .W       (W),
      .AW      (AW),
      .AUTO_TO (AUTO_TO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .adc_pair     (adc_pair),
      .sample_valid (sample_valid),
      .trig_src     (trig_src),
      .trig_slope   (trig_slope),
      .trig_level   (trig_level),
      .trig_hyst    (trig_hyst),
      .mode         (mode),
      .pretrig      (pretrig),
      .arm          (arm),
      .rd_release   (rd_release),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .frame_valid  (frame_valid),
      .frame_half   (frame_half),
      .trig_addr    (trig_addr),
      .forced       (forced),
      .state_o      (state_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Every write the DUT makes must match the next scoreboard entry.
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_write", 32'(wr_en), 32'd0);
         end else begin
            sb_t e;
            e = sb.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(e[AW+2*W:2*W]));
            check("wr_data", 32'(wr_data), 32'(e[2*W-1:0]));
         end
      end
   end

   // Drive one cycle; queue the expected write when the sample should be stored.
   task automatic drive(input int a, input int b, input bit v, input bit exp_wr);
      logic [2*W-1:0] d;
      d = {a[W-1:0], b[W-1:0]};
      adc_pair     = d;
      sample_valid = v;
      if (v && exp_wr) begin
         sb.push_back({exp_half, exp_ptr, d});
         exp_ptr = exp_ptr + 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 1'b0);
   endtask

   task automatic set_cfg(input bit src, input bit slope, input int level, input int hyst,
                          input logic [1:0] md, input int pre);
      trig_src   = src;
      trig_slope = slope;
      trig_level = level[W-1:0];
      trig_hyst  = hyst[W-1:0];
      mode       = md;
      pretrig    = pre[AW-1:0];
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      adc_pair     = '0;
      sample_valid = 1'b0;
      arm          = 1'b0;
      rd_release   = 1'b0;
      sb.delete();
      exp_ptr      = '0;
      exp_half     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic check_frame(input logic fv, input logic half, input int ta, input logic fo);
      check("sb_empty", 32'(sb.size()), 32'd0);
      check("frame_valid", 32'(frame_valid), 32'(fv));
      check("frame_half", 32'(frame_half), 32'(half));
      check("trig_addr", 32'(trig_addr), 32'(ta));
      check("forced", 32'(forced), 32'(fo));
   endtask

   // Ramp -500..+500 on A, level 0 / hyst 100: fires at value 0, sample index 500.
   task automatic run_ramp(input bit toggle);
      set_cfg(SrcA, SlopeRising, 0, 100, ModeNormal, 256);
      do_reset();
      idle(2);
      for (int i = 0; i < 256 + 245 + 767; i++) begin
         if (toggle) drive(int'($urandom), int'($urandom), 1'b0, 1'b0);
         drive((i <= 1000) ? -500 + i : 500, i * 3, 1'b1, 1'b1);
      end
      idle(3);
      check_frame(1'b1, 1'b0, 500, 1'b0);
      check("ramp_state", 32'(state_o), 32'(StPreFill));
   endtask

   initial begin
      // Reset values
      set_cfg(SrcA, SlopeRising, 0, 100, ModeNormal, 256);
      rst_n = 1'b0;
      #12;
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_frame_valid", 32'(frame_valid), 32'd0);
      check("rst_state", 32'(state_o), 32'(StIdle));

      // Normal mode ramp, continuous and with sample_valid toggling
      run_ramp(1'b0);
      run_ramp(1'b1);

      // Noise inside the hysteresis band never fires; then a clean step does
      set_cfg(SrcA, SlopeRising, 0, 100, ModeNormal, 0);
      do_reset();
      idle(2);
      for (int i = 0; i < 10000; i++) begin
         drive(int'($urandom_range(100)) - 50, i, 1'b1, 1'b1);
      end
      idle(1);
      check("noise_no_frame", 32'(frame_valid), 32'd0);
      check("noise_state", 32'(state_o), 32'(StArmed));
      drive(-200, 1, 1'b1, 1'b1);
      drive(200, 2, 1'b1, 1'b1);
      for (int i = 0; i < 1023; i++) drive(200, i, 1'b1, 1'b1);
      idle(3);
      check_frame(1'b1, 1'b0, 10001 % 1024, 1'b0);

      // Auto mode forces the trigger on the AUTO_TO-th armed sample
      set_cfg(SrcA, SlopeRising, 0, 100, ModeAuto, 0);
      do_reset();
      idle(2);
      for (int i = 0; i < AUTO_TO + 1022; i++) drive(0, i, 1'b1, 1'b1);
      idle(1);
      check("auto_not_yet", 32'(frame_valid), 32'd0);
      check("auto_state", 32'(state_o), 32'(StPost));
      drive(0, 7, 1'b1, 1'b1);
      idle(3);
      check_frame(1'b1, 1'b0, AUTO_TO - 1, 1'b1);

      // Single shot: nothing before arm, one frame after, nothing after that
      set_cfg(SrcA, SlopeRising, 0, 100, ModeSingle, 4);
      do_reset();
      for (int i = 0; i < 4; i++) drive((i % 2) ? 200 : -200, i, 1'b1, 1'b0);
      idle(1);
      check("single_wait_state", 32'(state_o), 32'(StIdle));
      arm = 1'b1;
      idle(1);
      arm = 1'b0;
      for (int i = 0; i < 5; i++) drive(-200, i, 1'b1, 1'b1);
      drive(200, 5, 1'b1, 1'b1);
      for (int i = 0; i < 1019; i++) drive(200, i, 1'b1, 1'b1);
      idle(3);
      check_frame(1'b1, 1'b0, 5, 1'b0);
      check("single_done_state", 32'(state_o), 32'(StIdle));
      for (int i = 0; i < 6; i++) drive((i % 2) ? 200 : -200, i, 1'b1, 1'b0);
      check("single_no_rearm", 32'(state_o), 32'(StIdle));
      check("single_no_write", 32'(wr_en), 32'd0);

      // Channel B, falling; reader holds frame 0 so frame 1 stalls in DONE
      set_cfg(SrcB, SlopeFalling, 0, 100, ModeNormal, 0);
      do_reset();
      idle(2);
      drive(11, 200, 1'b1, 1'b1);
      drive(12, -200, 1'b1, 1'b1);
      for (int i = 0; i < 1023; i++) drive(i, -200, 1'b1, 1'b1);
      idle(2);
      exp_half = 1'b1;
      check("f0_half", 32'(frame_half), 32'd0);
      drive(13, 200, 1'b1, 1'b1);
      drive(14, -200, 1'b1, 1'b1);
      for (int i = 0; i < 1023; i++) drive(i, -200, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) drive(i, 200, 1'b1, 1'b0);
      check("stall_state", 32'(state_o), 32'(StDone));
      check("stall_wr_en", 32'(wr_en), 32'd0);
      check_frame(1'b1, 1'b0, 1, 1'b0);
      rd_release = 1'b1;
      idle(1);
      rd_release = 1'b0;
      check_frame(1'b1, 1'b1, 2, 1'b0);
      rd_release = 1'b1;
      idle(1);
      rd_release = 1'b0;
      check("release_clears", 32'(frame_valid), 32'd0);

      // Reset during POST aborts everything
      set_cfg(SrcA, SlopeRising, 0, 100, ModeNormal, 0);
      do_reset();
      idle(2);
      drive(-200, 1, 1'b1, 1'b1);
      drive(200, 2, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) drive(200, i, 1'b1, 1'b1);
      drive(77, 77, 1'b0, 1'b0);
      check("pre_rst_state", 32'(state_o), 32'(StPost));
      check("pre_rst_sb", 32'(sb.size()), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("post_rst_state", 32'(state_o), 32'(StIdle));
      check("post_rst_wr_en", 32'(wr_en), 32'd0);
      check("post_rst_wr_addr", 32'(wr_addr), 32'd0);
      check("post_rst_wr_data", 32'(wr_data), 32'd0);
      check("post_rst_fv", 32'(frame_valid), 32'd0);
      check("post_rst_taddr", 32'(trig_addr), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
